ofm_axi_write_buffer: RTL
=========================

// Module: ofm_axi_write_buffer
// PURPOSE
//  Buffers OFM beats produced by the functional unit (write_out_ofm_en_1 / ofm_data_out_1) and drains
//  them to DDR as AXI4 INCR write bursts. Sits directly downstream of the functional unit.
//  Issues one burst at a time, never crosses a 4 KB boundary, and reports layer-write completion.
// PARAMETERS
//  DATA_WIDTH   256          beat width; AWSIZE = log2(DATA_WIDTH/8)
//  ADDR_WIDTH   32           AXI address width
//  ID_WIDTH     4            AXI ID width; AWID driven to 0
//  FIFO_DEPTH   512          beat FIFO depth; power of 2, >= 2*BURST_LEN
//  BURST_LEN    16           maximum beats per burst, 1..256
//  AFULL_MARGIN 4            almost_full asserts when free entries <= AFULL_MARGIN
// PORTS
//  M_AXI_ACLK     in   1            clock
//  M_AXI_ARESETN  in   1            synchronous active-low reset
//  start          in   1            pulse: latch base_addr/total_beats; accepted only when busy=0
//  base_addr      in   ADDR_WIDTH   layer OFM byte address; must be beat-aligned
//  total_beats    in   24           beats to write this layer; 0 = done next cycle, no AXI traffic
//  wr_en          in   1            OFM beat valid
//  wr_data        in   DATA_WIDTH   OFM beat
//  almost_full    out  1            producer stall request
//  overflow       out  1            sticky: wr_en seen while FIFO full; cleared by start
//  busy           out  1            high from accepted start until done
//  done           out  1            1-cycle pulse after last B response
//  M_AXI_AW*      out  ID,ADDR,8,3,2,1  AWID/AWADDR/AWLEN/AWSIZE/AWBURST(=INCR)/AWVALID; AWREADY in
//  M_AXI_W*       out  DATA,DATA/8,1,1  WDATA/WSTRB(all ones)/WLAST/WVALID; WREADY in
//  M_AXI_B*       in   2,1              BRESP/BVALID; BREADY out
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=IDLE, counters 0; reset mid-burst abandons the burst.
//  FIFO: first-word-fall-through; write at cycle N readable as WDATA at N+1. wr_en while full:
//   beat dropped, overflow set. wr_en while busy=0 is still stored.
//  FSM IDLE->ADDR when busy and fifo_count >= blen; blen = min(BURST_LEN, beats_left,
//   (4096 - addr[11:0]) / (DATA_WIDTH/8)).
//  ADDR: AWVALID=1, AWADDR=cur_addr, AWLEN=blen-1; AW fields stable until AWREADY; -> DATA.
//  DATA: WVALID=1 while beat count < blen; pop on WVALID&WREADY; WLAST on beat blen-1; -> RESP
//   on last handshake. WVALID never asserted before AW handshake.
//  RESP: BREADY=1; on BVALID: cur_addr += blen*DATA_WIDTH/8, beats_left -= blen;
//   beats_left==0 -> done pulse, busy=0, IDLE; else -> IDLE (next burst evaluated next cycle).
//  BRESP != OKAY: logged only (see CONFIGURATION); no retry.
//  Single outstanding burst; min AW-to-AW spacing = blen + 3 cycles with zero-wait slave.
//  Simultaneous push and pop: fifo_count unchanged. start while busy: ignored.
//  Beats left in FIFO after done are flushed by the next start's data stream (not cleared).
// CONFIGURATION
//  OFM_WB_BRESP_CNT_EN defined: adds output bresp_err_cnt [15:0], increments (saturating at
//   16'hFFFF) on each BVALID&BREADY with BRESP!=0; cleared by reset and accepted start.
//  Undefined: port absent, BRESP ignored, no counter logic.
// TESTING
//  1 total_beats=32, BURST_LEN=16, base 0x1000, zero-wait slave -> 2 bursts AWLEN=15 at 0x1000,
//    0x1200; 32 beats in order; done 1 cycle after 2nd BVALID.
//  2 base 0x1F80, total_beats=8 -> bursts 4 beats @0x1F80 then 4 beats @0x2000 (4 KB split).
//  3 total_beats=20 -> AWLEN=15 then AWLEN=3; WLAST exactly on beats 16 and 20.
//  4 WREADY low 5 cycles mid-burst, AWREADY delayed 3 cycles -> WDATA/AW fields held; no beat
//    lost or duplicated.
//  5 FIFO_DEPTH=32: push 33 beats with AXI stalled -> almost_full at 28 beats used, overflow=1,
//    beat 33 dropped.
//  6 reset at DATA beat 7 then start total_beats=0 -> all outputs 0; done pulse 1 cycle after
//    start, no AWVALID.

Source files
------------

// File: rtl/ofm_axi_write_buffer.sv
// OFM beat FIFO draining to DDR as single-outstanding AXI4 INCR write bursts that never cross 4 KB.
// Optional OFM_WB_BRESP_CNT_EN adds a saturating count of non-OKAY write responses (bresp_err_cnt).
module ofm_axi_write_buffer #(
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int FIFO_DEPTH   = 512,
    parameter int BURST_LEN    = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [23:0]             total_beats,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    almost_full,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done,
`ifdef OFM_WB_BRESP_CNT_EN
    output logic [15:0]             bresp_err_cnt,
`endif
    output logic [ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [2:0] AXSIZE = 3'(OFF_W);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    full, push, pop, accept;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [23:0]             beats_left;
    logic [7:0]              aw_len_q;
    logic [7:0]              beat_cnt;
    logic [8:0]              blen_q, blen_calc;
    logic [12:0]             room_beats;

    function automatic logic [8:0] burst_beats(input logic [23:0] left, input logic [12:0] room);
        logic [23:0] m;
        m = 24'(BURST_LEN);
        if (left < m) m = left;
        if ({11'd0, room} < m) m = {11'd0, room};
        return 9'(m);
    endfunction

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign push      = wr_en && !full;
    assign pop       = M_AXI_WVALID && M_AXI_WREADY;
    assign accept    = start && !busy;
    assign room_beats = (13'd4096 - {1'b0, cur_addr[11:0]}) >> OFF_W;
    assign blen_calc = burst_beats(beats_left, room_beats);
    assign blen_q    = {1'b0, aw_len_q} + 9'd1;

    // FIFO storage is data only; pointers and occupancy carry the reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (busy && beats_left != 24'd0 && 32'(count) >= 32'(blen_calc)) state_d = S_ADDR;
            S_ADDR: if (M_AXI_AWREADY) state_d = S_DATA;
            S_DATA: if (pop && M_AXI_WLAST) state_d = S_RESP;
            S_RESP: if (M_AXI_BVALID) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            cur_addr   <= '0;
            beats_left <= '0;
            aw_len_q   <= '0;
            beat_cnt   <= '0;
        end else begin
            done     <= 1'b0;
            overflow <= (accept ? 1'b0 : overflow) | (wr_en && full);
            if (accept) begin
                cur_addr   <= base_addr;
                beats_left <= total_beats;
                busy       <= (total_beats != 24'd0);
                done       <= (total_beats == 24'd0);
            end
            if (state_q == S_IDLE && state_d == S_ADDR) aw_len_q <= 8'(blen_calc - 9'd1);
            if (state_q == S_ADDR)  beat_cnt <= '0;
            else if (pop)           beat_cnt <= beat_cnt + 8'd1;
            // Burst retires on the write response; the next one is planned from IDLE.
            if (state_q == S_RESP && M_AXI_BVALID) begin
                cur_addr   <= cur_addr + (ADDR_WIDTH'(blen_q) << OFF_W);
                beats_left <= beats_left - 24'(blen_q);
                if (beats_left == 24'(blen_q)) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

`ifdef OFM_WB_BRESP_CNT_EN
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN)
            bresp_err_cnt <= '0;
        else if (accept)
            bresp_err_cnt <= '0;
        else if (M_AXI_BVALID && M_AXI_BREADY && M_AXI_BRESP != 2'b00 && bresp_err_cnt != 16'hFFFF)
            bresp_err_cnt <= bresp_err_cnt + 16'd1;
    end
`else
    logic [1:0] unused_bresp;
    assign unused_bresp = M_AXI_BRESP;
`endif

    assign almost_full   = (32'(FIFO_DEPTH) - 32'(count)) <= 32'(AFULL_MARGIN);
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = cur_addr;
    assign M_AXI_AWLEN   = aw_len_q;
    assign M_AXI_AWVALID = (state_q == S_ADDR);
    assign M_AXI_AWSIZE  = M_AXI_AWVALID ? AXSIZE : 3'd0;
    assign M_AXI_AWBURST = M_AXI_AWVALID ? 2'b01 : 2'b00;
    assign M_AXI_WVALID  = (state_q == S_DATA);
    assign M_AXI_WDATA   = M_AXI_WVALID ? mem[rd_ptr] : '0;
    assign M_AXI_WSTRB   = M_AXI_WVALID ? '1 : '0;
    assign M_AXI_WLAST   = M_AXI_WVALID && (beat_cnt == aw_len_q);
    assign M_AXI_BREADY  = (state_q == S_RESP);

endmodule
